present_sbox_serial: RTL
========================

PRESENT_SBOX_SERIAL -- requirements
Module: present_sbox_serial

Interface
REQ-001 SHALL have parameter: LANES, 1, S-boxes applied per cycle; legal values 1, 2, 4, 8, 16; other values are a compile-time error.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  state presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept state.
REQ-006 SHALL have port: state  input  [0:63]  64-bit cipher state; nibble k is state[4k:4k+3], with state[4k] as the nibble MSB.
REQ-007 SHALL have port: out_valid  output  1  res holds the substituted state.
REQ-008 SHALL have port: out_ready  input  1  downstream (pLayer) consumes res.
REQ-009 SHALL have port: res  output  [0:63]  substituted state, same nibble mapping as state.
REQ-010 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE with rst low.
REQ-013 SHALL, in IDLE on in_valid&&in_ready, load state into the data register, clear the nibble counter and go to RUN.
REQ-014 SHALL, in each RUN cycle, replace the LANES most-significant nibbles (lowest indices) with their S-box image and rotate the register left by 4*LANES bits.
REQ-015 SHALL use forward S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (input 0..F).
REQ-016 SHALL advance the counter by LANES per RUN cycle, modulo 16, and go to DONE on the cycle in which the counter wraps to 0.
REQ-017 SHALL assert out_valid exactly N=16/LANES rising edges after the accepting edge; N=16 for LANES=1.
REQ-018 SHALL assert out_valid only in DONE and hold res stable while out_valid && !out_ready.
REQ-019 SHALL, in DONE on out_ready, return to IDLE; in_ready rises on the following cycle (no same-cycle accept).
REQ-020 SHALL ignore in_valid outside IDLE; it has no effect on state.
REQ-021 SHALL drive res from the data register at all times; its value is meaningful only with out_valid.

Reset
REQ-022 SHALL, with rst high at a rising edge, set FSM=IDLE, counter=0, data register=0, out_valid=0 and busy=0.
REQ-023 SHALL force in_ready=0 while rst is high.
REQ-024 SHALL discard any in-flight state on reset in RUN or DONE; no partial output.

Configuration
REQ-025 SHALL, with PRESENT_SBOX_INV_EN defined, add input port dec (1 bit), sampled at the accepting handshake and held for the operation.
REQ-026 SHALL, with dec=1, apply inverse S-box 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A; latency is identical.
REQ-027 SHALL, without PRESENT_SBOX_INV_EN, omit port dec and the inverse table, and apply the forward S-box only.

Structure
REQ-028 SHALL place the following in shared package present_pkg: STATE_W=64, the nibble typedef, the SBOX and SBOX_INV tables, and the FSM state enum.
REQ-029 SHALL instantiate LANES copies of sub-module present_sbox4 (4-bit combinational lookup, with inv select when the macro is defined).

Verification
REQ-030 SHALL cover: LANES=1, state=0x0000000000000000 -> res=0xCCCCCCCCCCCCCCCC, with out_valid at edge 16 after accept.
REQ-031 SHALL cover: state=0x0123456789ABCDEF -> res=0xC56B90AD3EF84712, with out_valid at edge 16 for LANES=1 and edge 4 for LANES=4.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE -> res unchanged, in_ready=0 and in_valid ignored; in_ready=1 one cycle after out_ready.
REQ-033 SHALL cover: rst pulsed at RUN cycle 7 -> out_valid=0 and busy=0; the next operation on 0x0123456789ABCDEF gives the correct result.
REQ-034 SHALL cover: PRESENT_SBOX_INV_EN defined, dec=1, state=0xC56B90AD3EF84712 -> res=0x0123456789ABCDEF.
REQ-035 SHALL cover: back-to-back operations with in_valid held high -> accepts spaced N+2 cycles apart, each result correct.

Source files
------------

// File: rtl/present_pkg.sv
// present_pkg: shared width, nibble type, S-box tables and FSM encoding for the PRESENT S-box layer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Defining PRESENT_SBOX_INV_EN also provides the inverse S-box table.
package present_pkg;

  localparam int STATE_W = 64;
  localparam int NIBBLES = STATE_W / 4;

  typedef logic [3:0] nibble_t;

  // Forward PRESENT S-box, indexed by input nibble 0..F.
  localparam nibble_t SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

`ifdef PRESENT_SBOX_INV_EN
  // Inverse PRESENT S-box, used for decryption.
  localparam nibble_t SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: one 4-bit PRESENT S-box lookup.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: x = input nibble, y = substituted nibble; inv (only with PRESENT_SBOX_INV_EN) selects the inverse table.
module present_sbox4
  import present_pkg::*;
(
  input  nibble_t x,
`ifdef PRESENT_SBOX_INV_EN
  input  logic    inv,
`endif
  output nibble_t y
);

`ifdef PRESENT_SBOX_INV_EN
  assign y = inv ? SBOX_INV[x] : SBOX[x];
`else
  assign y = SBOX[x];
`endif

endmodule

// File: rtl/present_sbox_serial.sv
// present_sbox_serial: PRESENT S-box layer applied LANES nibbles per cycle over a rotating 64-bit register.
// Latency: out_valid 16/LANES rising edges after the accepting edge.
// Backpressure: one operation in flight; res held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/state accept a state; out_valid/out_ready/res
// return it substituted; busy is high in RUN or DONE. Optional macro PRESENT_SBOX_INV_EN adds dec
// (sampled at accept) to select the inverse S-box.
module present_sbox_serial
  import present_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] state,
`ifdef PRESENT_SBOX_INV_EN
  input  logic               dec,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] res,
  output logic               busy
);

  localparam int SUB_W = 4 * LANES;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("present_sbox_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_t               fsm_q;
  fsm_t               fsm_d;
  logic [3:0]         cnt_q;
  logic [4:0]         cnt_sum;
  logic               wrap;
  logic [STATE_W-1:0] data_q;
  logic [STATE_W-1:0] data_step;
  logic [SUB_W-1:0]   sub;
  logic               load;
  logic               step;
`ifdef PRESENT_SBOX_INV_EN
  logic               dec_q;
`endif

  // Internally bit 63 is the MSB of nibble 0, so the positional copy keeps the nibble order.
  assign res       = data_q;
  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);

  // Carry out of the 4-bit counter marks the last RUN cycle; works for LANES=16 too.
  assign cnt_sum = {1'b0, cnt_q} + 5'(LANES);
  assign wrap    = cnt_sum[4];

  // Substitute the LANES leading nibbles; the rotation below brings fresh nibbles to the front.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    present_sbox4 u_sbox (
      .x   (data_q[STATE_W-1-4*i -: 4]),
`ifdef PRESENT_SBOX_INV_EN
      .inv (dec_q),
`endif
      .y   (sub[SUB_W-1-4*i -: 4])
    );
  end

  // Rotate left by 4*LANES with the substituted nibbles re-entering at the tail; after
  // 16/LANES steps every nibble has been substituted once and is back in its own slot.
  if (LANES == 16) begin : g_full
    assign data_step = sub;
  end else begin : g_rot
    assign data_step = {data_q[STATE_W-1-SUB_W:0], sub};
  end

  always_comb begin
    fsm_d = fsm_q;
    load  = 1'b0;
    step  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load  = 1'b1;
          fsm_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (wrap) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
`ifdef PRESENT_SBOX_INV_EN
      dec_q  <= 1'b0;
`endif
    end else begin
      fsm_q <= fsm_d;
      if (load) begin
        data_q <= state;
        cnt_q  <= '0;
`ifdef PRESENT_SBOX_INV_EN
        dec_q  <= dec;
`endif
      end else if (step) begin
        data_q <= data_step;
        cnt_q  <= cnt_sum[3:0];
      end
    end
  end

endmodule
